// File: rtl/vga_row_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_row_fetcher_pkg
// Purpose  : Shared constants and fetch FSM encoding for the VGA row fetcher
// Revision : 1.0
// ============================================================================
package vga_row_fetcher_pkg;

  localparam int BEATS        = 80;
  localparam int PIX_PER_BEAT = 8;
  localparam int H_ACTIVE     = 640;
  localparam int H_LAST       = 799;
  localparam int SWAP_H       = 798;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

endpackage : vga_row_fetcher_pkg
`default_nettype wire

// File: rtl/vga_row_fetcher_ram.sv
`default_nettype none
// ============================================================================
// Module   : row_buffer_ram
// Purpose  : Two-bank line buffer; one write port, one registered read port
// Revision : 1.0
// ============================================================================
module row_buffer_ram #(
  parameter int DATA_W = 128,
  parameter int WORDS  = vga_row_fetcher_pkg::BEATS
) (
  input  logic              clk_25M,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [7:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 * WORDS;
  localparam logic [7:0] C_WORDS = 8'(WORDS);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [7:0]        w_wr_lin;
  logic [7:0]        w_rd_lin;
  logic              w_wr_ok;
  logic              w_rd_ok;

  // Address MSB selects the bank; the low 7 bits index a beat within it.
  always_comb begin
    w_wr_lin = {1'b0, wr_addr[6:0]} + (wr_addr[7] ? C_WORDS : 8'd0);
    w_rd_lin = {1'b0, rd_addr[6:0]} + (rd_addr[7] ? C_WORDS : 8'd0);
    w_wr_ok  = ({1'b0, wr_addr[6:0]} < C_WORDS);
    w_rd_ok  = ({1'b0, rd_addr[6:0]} < C_WORDS);
  end

  always_ff @(posedge clk_25M) begin
    if (wr_en && w_wr_ok) begin
      r_mem[w_wr_lin] <= wr_data;
    end
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (w_rd_ok) begin
      rd_data <= r_mem[w_rd_lin];
    end
  end

endmodule : row_buffer_ram
`default_nettype wire

// File: rtl/vga_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : vga_row_fetcher
// Purpose  : Fetches each display row into a ping-pong buffer, serves pixels
// Revision : 1.0
// ============================================================================
module vga_row_fetcher #(
  parameter int ADDR_W = 27,
  parameter int BEATS  = vga_row_fetcher_pkg::BEATS
) (
  input  logic              clk_25M,
  input  logic              rst_n,
  input  logic              start_frame,
  input  logic              start_row,
  input  logic [9:0]        h_counter,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [127:0]      rd_data,
  output logic [15:0]       pixel_data,
  output logic              busy,
  output logic              underrun
);

  import vga_row_fetcher_pkg::*;

  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int IDX_W  = 7;
  localparam int LANE_W = $clog2(PIX_PER_BEAT);

  localparam logic [CNT_W-1:0]  C_LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] C_ROW_STEP  = ADDR_W'(BEATS);
  localparam logic [9:0]        C_H_LAST    = 10'(H_LAST);
  localparam logic [9:0]        C_SWAP_H    = 10'(SWAP_H);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic              w_req;
  logic              w_busy;
  logic              w_wr_en;
  logic              w_fetch_done;
  logic              w_start_fetch;
  logic              w_swap;

  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] w_row_src;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  r_resp_cnt;
  logic              r_fill_bank;
  logic              r_disp_bank;
  logic              r_swap_pending;
  logic              r_row_ready;
  logic              r_underrun;

  logic [9:0]        w_la;
  logic [7:0]        w_ram_waddr;
  logic [7:0]        w_ram_raddr;
  logic [127:0]      w_ram_rdata;
  logic [127:0]      w_word_shift;
  logic [LANE_W-1:0] r_lane;

  // ---------------------------------------------------------------- fetch FSM
  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_busy       = 1'b0;
    w_wr_en      = 1'b0;
    w_fetch_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_row) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req   = 1'b1;
        w_busy  = 1'b1;
        w_wr_en = rd_valid;
        if (rd_ack && (r_req_cnt == C_LAST_BEAT)) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_busy  = 1'b1;
        w_wr_en = rd_valid;
        if (rd_valid && (r_resp_cnt == C_LAST_BEAT)) begin
          w_fetch_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_row_src     = start_frame ? frame_base : r_row_base;
    w_start_fetch = start_row && (r_state == ST_IDLE);
    w_swap        = r_swap_pending && (h_counter == C_SWAP_H);
  end

  // -------------------------------------------------------- fetch datapath
  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      r_req_addr     <= '0;
      r_row_base     <= '0;
      r_req_cnt      <= '0;
      r_resp_cnt     <= '0;
      r_fill_bank    <= 1'b0;
      r_disp_bank    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_row_ready    <= 1'b0;
    end else begin
      if (w_req && rd_ack) begin
        r_req_addr <= r_req_addr + C_ADDR_ONE;
        r_req_cnt  <= r_req_cnt + C_CNT_ONE;
      end
      if (w_wr_en) begin
        r_resp_cnt <= r_resp_cnt + C_CNT_ONE;
      end
      if (w_fetch_done) begin
        r_row_ready <= 1'b1;
      end
      // A late start_row still advances the row pointer so later rows stay aligned.
      if (start_row) begin
        r_row_base     <= w_row_src + C_ROW_STEP;
        r_swap_pending <= 1'b1;
      end
      if (w_start_fetch) begin
        r_req_addr  <= w_row_src;
        r_req_cnt   <= '0;
        r_resp_cnt  <= '0;
        r_fill_bank <= ~r_disp_bank;
        r_row_ready <= 1'b0;
      end
      if (w_swap) begin
        r_disp_bank    <= ~r_disp_bank;
        r_swap_pending <= 1'b0;
        r_row_ready    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if ((start_row && !w_start_fetch) || (w_swap && !r_row_ready)) begin
      r_underrun <= 1'b1;
    end else if (start_frame) begin
      r_underrun <= 1'b0;
    end
  end

  // ------------------------------------------------------------- read side
  // Read one pixel ahead so the registered RAM output lines up with h_counter.
  always_comb begin
    w_la        = (h_counter == C_H_LAST) ? 10'd0 : (h_counter + 10'd1);
    w_ram_raddr = {r_disp_bank, w_la[9:3]};
    w_ram_waddr = {r_fill_bank, IDX_W'(r_resp_cnt)};
  end

  row_buffer_ram #(
    .DATA_W (128),
    .WORDS  (BEATS)
  ) u_row_buffer_ram (
    .clk_25M (clk_25M),
    .rst_n   (rst_n),
    .wr_en   (w_wr_en),
    .wr_addr (w_ram_waddr),
    .wr_data (rd_data),
    .rd_addr (w_ram_raddr),
    .rd_data (w_ram_rdata)
  );

  always_ff @(posedge clk_25M) begin
    if (!rst_n) begin
      r_lane <= '0;
    end else begin
      r_lane <= w_la[LANE_W-1:0];
    end
  end

  // Lane 0 occupies the most significant halfword of the beat.
  always_comb begin
    w_word_shift = w_ram_rdata << {r_lane, 4'b0000};
    pixel_data   = w_word_shift[127:112];
  end

  assign rd_req   = w_req;
  assign rd_addr  = r_req_addr;
  assign busy     = w_busy;
  assign underrun = r_underrun;

endmodule : vga_row_fetcher
`default_nettype wire

// File: tb/tb_vga_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_row_fetcher
// Purpose  : Directed, self-checking bench with a line-level behavioural model
// Revision : 1.0
// ============================================================================
module tb_vga_row_fetcher;

  localparam int ADDR_W = 27;
  localparam int NBEAT  = 80;
  localparam int NLINES = 12;

  logic              clk_25M;
  logic              rst_n;
  logic              start_frame;
  logic              start_row;
  logic [9:0]        h_counter;
  logic [ADDR_W-1:0] frame_base;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [127:0]      rd_data;
  logic [15:0]       pixel_data;
  logic              busy;
  logic              underrun;

  vga_row_fetcher #(
    .ADDR_W (ADDR_W),
    .BEATS  (NBEAT)
  ) dut (
    .clk_25M     (clk_25M),
    .rst_n       (rst_n),
    .start_frame (start_frame),
    .start_row   (start_row),
    .h_counter   (h_counter),
    .frame_base  (frame_base),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_ack      (rd_ack),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .pixel_data  (pixel_data),
    .busy        (busy),
    .underrun    (underrun)
  );

  initial clk_25M = 1'b0;
  always #5 clk_25M = ~clk_25M;

  int n_cmp  = 0;
  int n_fail = 0;
  int ln     = 0;
  int cyc    = 0;

  // Model state: one outstanding fetch, one pending row, one displayed row.
  bit m_rst, m_active, m_ready, m_pend, m_disp_ok, m_under, m_done, ack_slow;
  int m_acks, m_deliv, m_base, m_pend_base, m_next_base, m_disp_base;
  bit obs_req;
  int obs_addr;

  typedef struct { int addr; int due; } rsp_t;
  rsp_t mq[$];

  function automatic logic [127:0] mem_word(input int a);
    logic [127:0] w;
    logic [31:0]  av;
    av = a;
    w  = '0;
    for (int p = 0; p < 8; p++) begin
      w[127-16*p -: 16] = {av[12:0], 3'(p)};
    end
    return w;
  endfunction

  function automatic logic [15:0] exp_pix(input int base, input int hh);
    logic [31:0] av;
    av = base + hh / 8;
    return {av[12:0], 3'(hh % 8)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (line %0d, h %0d)", name, act, exp, ln, h_counter);
    end
  endtask

  // Apply what the DUT saw at the edge that just passed.
  task automatic commit_edge();
    bit was_active, ready_before;
    int src;
    if (!rst_n) begin
      m_rst = 1; m_active = 0; m_acks = 0; m_deliv = 0; m_ready = 0; m_pend = 0;
      m_next_base = 0; m_disp_ok = 0; m_disp_base = -1; m_under = 0; m_done = 0;
      mq.delete();
    end else begin
      m_rst        = 0;
      was_active   = m_active;
      ready_before = m_ready;
      if (rd_ack && obs_req) mq.push_back('{obs_addr, cyc + 2});
      if (rd_ack && m_active && m_acks < NBEAT) m_acks++;
      if (rd_valid && m_active) begin
        m_deliv++;
        if (m_deliv == NBEAT) begin m_active = 0; m_ready = 1; m_done = 1; end
      end
      if (start_row) begin
        src = start_frame ? int'(frame_base) : m_next_base;
        if (start_frame) m_under = 0;
        if (was_active) m_under = 1;
        else begin
          m_active = 1; m_base = src; m_acks = 0; m_deliv = 0; m_ready = 0; m_done = 0;
        end
        m_pend = 1; m_pend_base = src; m_next_base = src + NBEAT;
      end
      if (h_counter == 10'd798 && m_pend) begin
        m_disp_base = m_pend_base;
        m_disp_ok   = ready_before;
        if (!ready_before) m_under = 1;
        m_ready = 0;
        m_pend  = 0;
      end
    end
    cyc++;
  endtask

  task automatic drive_next();
    h_counter = (h_counter == 10'd799) ? 10'd0 : h_counter + 10'd1;
    if (h_counter == 10'd0) begin
      ln++;
      if (!m_disp_ok && m_done && m_disp_base == m_base) m_disp_ok = 1;
    end
    rst_n       = !(cyc < 5 || (ln == 9 && h_counter >= 10'd660 && h_counter < 10'd663));
    start_row   = 1'b0;
    start_frame = 1'b0;
    if (rst_n && h_counter == 10'd640) begin
      case (ln)
        1:       begin start_row = 1; start_frame = 1; frame_base = 27'h100; ack_slow = 0; end
        2, 3, 9: begin start_row = 1; ack_slow = 0; end
        6:       begin start_row = 1; ack_slow = 1; end
        8:       begin start_row = 1; start_frame = 1; frame_base = 27'h100; ack_slow = 0; end
        10:      begin start_row = 1; start_frame = 1; frame_base = 27'h200; ack_slow = 0; end
        default: ;
      endcase
    end
    rd_ack = ack_slow ? (cyc % 3 == 0) : 1'b1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      rd_valid = 1'b0;
      rd_data  = '0;
    end
  endtask

  task automatic compare();
    bit exp_req;
    if (m_rst) begin
      chk("rst_rd_req", rd_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_pixel", pixel_data, 0);
      chk("rst_rd_addr", rd_addr, 0);
    end else begin
      exp_req = m_active && (m_acks < NBEAT);
      chk("rd_req", rd_req, exp_req);
      chk("busy", busy, m_active);
      chk("underrun", underrun, m_under);
      if (exp_req) chk("rd_addr", rd_addr, m_base + m_acks);
      if (m_disp_ok && h_counter < 10'd640) chk("pixel", pixel_data, exp_pix(m_disp_base, int'(h_counter)));
      // Hand-computed anchors for the model itself.
      if (exp_req && m_base == 32'h100 && m_acks == 0)  chk("lit_addr_first", rd_addr, 32'h100);
      if (exp_req && m_base == 32'h100 && m_acks == 79) chk("lit_addr_last", rd_addr, 32'h14F);
      if (exp_req && m_base == 32'h150 && m_acks == 0)  chk("lit_addr_row1_first", rd_addr, 32'h150);
      if (exp_req && m_base == 32'h150 && m_acks == 79) chk("lit_addr_row1_last", rd_addr, 32'h19F);
      if (m_disp_ok && m_disp_base == 32'h100 && h_counter == 10'd0)   chk("lit_r0_h0", pixel_data, 16'h0800);
      if (m_disp_ok && m_disp_base == 32'h100 && h_counter == 10'd9)   chk("lit_r0_h9", pixel_data, 16'h0809);
      if (m_disp_ok && m_disp_base == 32'h100 && h_counter == 10'd639) chk("lit_r0_h639", pixel_data, 16'h0A7F);
      if (m_disp_ok && m_disp_base == 32'h150 && h_counter == 10'd0)   chk("lit_r1_h0", pixel_data, 16'h0A80);
      if (ln == 0 && h_counter == 10'd20) chk("lit_idle_req", rd_req, 0);
      if (ln == 7 && h_counter == 10'd0)  chk("lit_underrun_set", underrun, 1);
      if (ln == 9 && h_counter == 10'd0)  chk("lit_underrun_clr", underrun, 0);
    end
    obs_req  = rd_req;
    obs_addr = int'(rd_addr);
  endtask

  initial begin
    rst_n = 1'b0; start_frame = 1'b0; start_row = 1'b0; h_counter = 10'd0;
    frame_base = '0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    ack_slow = 0; obs_req = 0; obs_addr = 0; m_disp_base = -1;
    for (int i = 0; i < NLINES * 800; i++) begin
      @(posedge clk_25M);
      #1;
      commit_edge();
      drive_next();
      compare();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_vga_row_fetcher
`default_nettype wire

// File: doc/vga_row_fetcher.md
# vga_row_fetcher

Memory-side counterpart of the VGA timing controller. On each `start_row` / `start_frame` pulse it fetches the next display row (640 RGB565 pixels, 80 × 128-bit beats) from frame memory into a ping-pong line buffer. It serves `pixel_data` indexed by the controller's `h_counter`, so pixel *h* is valid in the same cycle that `h_counter == h`. It sits between the memory read port and `vga_controller`, in the `clk_25M` domain.

## Interface

**Parameters**
- `ADDR_W`, 27: width of the 128-bit-word read address.
- `BEATS`, 80: beats per row (640 px × 16 b / 128 b).

**Ports** (clock and reset first)
- `clk_25M` in 1: pixel clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start_frame` in 1: one-cycle pulse, coincides with the first `start_row` of a frame.
- `start_row` in 1: one-cycle pulse at `h_counter == 640` of the line before a display line.
- `h_counter` in 10: horizontal position, 0..799.
- `frame_base` in ADDR_W: word address of row 0; sampled on `start_frame`.
- `rd_req` out 1: read request.
- `rd_addr` out ADDR_W: word address; held stable while `rd_req && !rd_ack`.
- `rd_ack` in 1: request accepted in this cycle.
- `rd_valid` in 1: response beat valid; responses return in request order.
- `rd_data` in 128: response data.
- `pixel_data` out 16: pixel for the current `h_counter`.
- `busy` out 1: row fetch in progress.
- `underrun` out 1: sticky flag; a row swap occurred before its fetch completed.

## Operation

**Fetch FSM** (`IDLE`, `REQ`, `WAIT`)
- `IDLE` to `REQ` on `start_row`:
  - Load `req_addr = row_base`, clear the request and response counters, set `swap_pending`.
  - Then advance `row_base += BEATS`.
  - If `start_frame` is also high, use `row_base = frame_base` for this fetch, and `frame_base + BEATS` afterwards.
- `REQ`: assert `rd_req` with `rd_addr = req_addr`. Each `rd_ack` increments the address and the request count. After the 80th ack, go to `WAIT`.
- `WAIT`: after the 80th `rd_valid` (response count reaches `BEATS`), set `row_ready` and go to `IDLE`.
- In both `REQ` and `WAIT`, each `rd_valid` writes `rd_data` into the back bank at the response index. Responses may arrive while still in `REQ`.
- `start_row` while `busy`:
  - Set `underrun`, still advance `row_base`.
  - Do not restart the fetch; the back bank keeps the in-flight fetch.

**Bank swap**
- At the clock edge where `h_counter == 798` and `swap_pending` is set: toggle the display bank and clear `swap_pending`.
- If `row_ready == 0` at that edge, set `underrun`. The swap still occurs.
- `row_ready` is cleared at the swap.
- No swap occurs on lines without a preceding `start_row` (vertical blank).

**Read side**
- Look-ahead index `la = (h_counter == 799) ? 0 : h_counter + 1`.
- RAM read address is `{display_bank, la[9:3]}`. `la[2:0]` is registered alongside the RAM output.
- Lane *p* maps to `pixel_data = word[127-16p -: 16]`, unmodified, with no byte swapping.
- For `la >= 640`, the read content is don't-care; the controller blanks it.

**Clearing and reset**
- `underrun` clears only on `start_frame` or reset.
- Reset mid-fetch aborts the fetch. The memory side shares `rst_n`.

## Timing

- Reset values: `rd_req=0`, `rd_addr=0`, `busy=0`, `underrun=0`, `pixel_data=0`; `row_base=0`, display bank 0, `swap_pending=0`, `row_ready=0`.
- `rd_req` rises one cycle after the `start_row` edge.
- Read latency is one cycle. `pixel_data` is driven only from the RAM output register and lane register through the lane mux, so pixel *h* appears while `h_counter == h`.
- Deadline: all 80 responses must arrive within 158 cycles of the `start_row` edge. This requires a sustained rate of at least 1 beat per 2 cycles.
- `busy` is high from the cycle after `start_row` through the cycle of the 80th `rd_valid`.
- Row 0 is fetched at v=524 and displayed at v=0. Row *n* is fetched during line *n−1*.

## Structure

- Shared package holds: `BEATS`, `PIX_PER_BEAT=8`, `H_ACTIVE=640`, `H_LAST=799`, `SWAP_H=798`, and the FSM state enum.
- Sub-module `row_buffer_ram`: simple dual-port RAM of 160×128 (bank bit as address MSB), one write port, one registered read port.
- Everything else stays in `vga_row_fetcher`.

## Test plan

- **Reset:** hold `rst_n=0` for 5 cycles → all outputs 0; `rd_req=0` for 10 cycles after release with no pulses.
- **First row fetch:** `start_frame`+`start_row` with `frame_base=0x100`; memory acks every cycle, 2-cycle response → `rd_addr` runs 0x100..0x14F; `busy` falls after the 80th beat; no `underrun`.
- **Pixel ordering:** beat *k*, lane *p* holds word `{6'd0, k[6:0], p[2:0]}` → at `h_counter = 8k+p` (0..639) on the next line, `pixel_data` equals that word; `h=0` is correct immediately after the swap.
- **Row progression and double buffering:** second `start_row` → addresses 0x150..0x19F; the line currently displayed still shows row 0 during the fetch; row 1 appears after the `h=798` swap.
- **Starved memory:** ack every 3rd cycle → fetch incomplete at `h=798` → `underrun=1`, held until the next `start_frame`, then 0.
- **Reset and blanking:** assert `rst_n=0` mid-`REQ` → `rd_req=0` and `busy=0` next cycle. Separately, lines without `start_row` → display bank unchanged.
